// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order commit controller at the writeback boundary (mask, redirect, RUN/INV_WAIT/IDLE FSM).
// Optional feature macro: COMMIT_IDLE_FSM_EN enables the IDLE wait-for-interrupt state.
module commit_ctrl #(
  parameter int COMMIT_WIDTH = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int FTQ_ID_WIDTH = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [COMMIT_WIDTH-1:0]              slot_valid_i,
  input  logic [COMMIT_WIDTH*ADDR_WIDTH-1:0]   slot_pc_i,
  input  logic [COMMIT_WIDTH-1:0]              slot_excp_i,
  input  logic [COMMIT_WIDTH*16-1:0]           slot_excp_num_i,
  input  logic [COMMIT_WIDTH*3-1:0]            slot_kind_i,
  input  logic [COMMIT_WIDTH-1:0]              slot_last_in_block_i,
  input  logic [COMMIT_WIDTH*FTQ_ID_WIDTH-1:0] slot_ftq_id_i,
  input  logic [ADDR_WIDTH-1:0]                csr_eentry_i,
  input  logic [ADDR_WIDTH-1:0]                csr_tlbrentry_i,
  input  logic [ADDR_WIDTH-1:0]                csr_era_i,
  input  logic                                 int_pending_i,
  input  logic                                 inv_ready_i,
  output logic                                 commit_ready_o,
  output logic [COMMIT_WIDTH-1:0]              commit_mask_o,
  output logic [COMMIT_WIDTH-1:0]              block_commit_mask_o,
  output logic                                 redirect_valid_o,
  output logic [ADDR_WIDTH-1:0]                redirect_pc_o,
  output logic [FTQ_ID_WIDTH-1:0]              flush_ftq_id_o,
  output logic                                 csr_excp_o,
  output logic                                 csr_ertn_o,
  output logic [ADDR_WIDTH-1:0]                csr_era_o,
  output logic [15:0]                          excp_num_o,
  output logic                                 excp_tlbrefill_o,
  output logic                                 inv_valid_o,
  output logic                                 in_idle_o
);

  typedef enum logic [1:0] {ST_RUN, ST_INV_WAIT, ST_IDLE} state_e;

  localparam logic [2:0] KIND_ERTN   = 3'd1;
  localparam logic [2:0] KIND_IDLE   = 3'd2;
  localparam logic [2:0] KIND_INVTLB = 3'd4;

  state_e                  state_q, state_d;
  logic                    rdr_valid_q, rdr_valid_d;
  logic [ADDR_WIDTH-1:0]   rdr_pc_q, rdr_pc_d;
  logic [FTQ_ID_WIDTH-1:0] flush_ftq_q, flush_ftq_d;
  logic                    excp_q, excp_d;
  logic                    ertn_q, ertn_d;
  logic [ADDR_WIDTH-1:0]   era_q, era_d;
  logic [15:0]             excp_num_q, excp_num_d;
  logic                    tlbr_q, tlbr_d;
  logic [ADDR_WIDTH-1:0]   saved_pc_q, saved_pc_d;
  logic [FTQ_ID_WIDTH-1:0] saved_ftq_q, saved_ftq_d;

  logic                    bnd_found, bnd_excp, is_bnd, bnd_tlbr;
  logic [ADDR_WIDTH-1:0]   bnd_pc;
  logic [15:0]             bnd_num;
  logic [2:0]              bnd_kind;
  logic [FTQ_ID_WIDTH-1:0] bnd_ftq;
  logic [COMMIT_WIDTH-1:0] slot_mask;

  // Oldest-first scan: slots before the boundary commit, the boundary commits unless it faulted.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bnd_found = 1'b0;
    bnd_excp  = 1'b0;
    is_bnd    = 1'b0;
    bnd_pc    = '0;
    bnd_num   = '0;
    bnd_kind  = '0;
    bnd_ftq   = '0;
    slot_mask = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (!bnd_found && slot_valid_i[i]) begin
        is_bnd       = slot_excp_i[i] || (slot_kind_i[i*3 +: 3] != 3'd0);
        slot_mask[i] = !slot_excp_i[i];
        if (is_bnd) begin
          bnd_found = 1'b1;
          bnd_excp  = slot_excp_i[i];
          bnd_pc    = slot_pc_i[i*ADDR_WIDTH +: ADDR_WIDTH];
          bnd_num   = slot_excp_num_i[i*16 +: 16];
          bnd_kind  = slot_kind_i[i*3 +: 3];
          bnd_ftq   = slot_ftq_id_i[i*FTQ_ID_WIDTH +: FTQ_ID_WIDTH];
        end
      end
    end
  end

  assign bnd_tlbr = bnd_num[2] | bnd_num[11];

  // The redirect cycle carries wrong-path slots, so nothing is accepted then.
  assign commit_ready_o      = (state_q == ST_RUN) && !rdr_valid_q;
  assign commit_mask_o       = slot_mask & {COMMIT_WIDTH{commit_ready_o}};
  assign block_commit_mask_o = commit_mask_o & slot_last_in_block_i;

  always_comb begin
    state_d     = state_q;
    saved_pc_d  = saved_pc_q;
    saved_ftq_d = saved_ftq_q;
    rdr_valid_d = 1'b0;
    rdr_pc_d    = '0;
    flush_ftq_d = '0;
    excp_d      = 1'b0;
    ertn_d      = 1'b0;
    era_d       = '0;
    excp_num_d  = '0;
    tlbr_d      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (commit_ready_o && bnd_found) begin
          flush_ftq_d = bnd_ftq;
          if (bnd_excp) begin
            rdr_valid_d = 1'b1;
            rdr_pc_d    = bnd_tlbr ? csr_tlbrentry_i : csr_eentry_i;
            excp_d      = 1'b1;
            era_d       = bnd_pc;
            excp_num_d  = bnd_num;
            tlbr_d      = bnd_tlbr;
          end else begin
            case (bnd_kind)
              KIND_ERTN: begin
                rdr_valid_d = 1'b1;
                rdr_pc_d    = csr_era_i;
                ertn_d      = 1'b1;
              end
              KIND_INVTLB: begin
                state_d     = ST_INV_WAIT;
                saved_pc_d  = bnd_pc;
                saved_ftq_d = bnd_ftq;
              end
              KIND_IDLE: begin
`ifdef COMMIT_IDLE_FSM_EN
                state_d     = ST_IDLE;
                saved_pc_d  = bnd_pc;
                saved_ftq_d = bnd_ftq;
`else
                rdr_valid_d = 1'b1;
                rdr_pc_d    = bnd_pc;
`endif
              end
              default: begin
                rdr_valid_d = 1'b1;
                rdr_pc_d    = bnd_pc + ADDR_WIDTH'(4);
              end
            endcase
          end
        end
      end
      ST_INV_WAIT: begin
        if (inv_ready_i) begin
          state_d     = ST_RUN;
          rdr_valid_d = 1'b1;
          rdr_pc_d    = saved_pc_q + ADDR_WIDTH'(4);
          flush_ftq_d = saved_ftq_q;
        end
      end
`ifdef COMMIT_IDLE_FSM_EN
      ST_IDLE: begin
        if (int_pending_i) begin
          state_d     = ST_RUN;
          rdr_valid_d = 1'b1;
          rdr_pc_d    = csr_eentry_i;
          flush_ftq_d = saved_ftq_q;
          excp_d      = 1'b1;
          era_d       = saved_pc_q + ADDR_WIDTH'(4);
          excp_num_d  = 16'h0001;
        end
      end
`endif
      default: state_d = ST_RUN;
    endcase
    if (!rdr_valid_d) flush_ftq_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      rdr_valid_q <= 1'b0;
      rdr_pc_q    <= '0;
      flush_ftq_q <= '0;
      excp_q      <= 1'b0;
      ertn_q      <= 1'b0;
      era_q       <= '0;
      excp_num_q  <= '0;
      tlbr_q      <= 1'b0;
      saved_pc_q  <= '0;
      saved_ftq_q <= '0;
    end else begin
      state_q     <= state_d;
      rdr_valid_q <= rdr_valid_d;
      rdr_pc_q    <= rdr_pc_d;
      flush_ftq_q <= flush_ftq_d;
      excp_q      <= excp_d;
      ertn_q      <= ertn_d;
      era_q       <= era_d;
      excp_num_q  <= excp_num_d;
      tlbr_q      <= tlbr_d;
      saved_pc_q  <= saved_pc_d;
      saved_ftq_q <= saved_ftq_d;
    end
  end

  assign redirect_valid_o = rdr_valid_q;
  assign redirect_pc_o    = rdr_pc_q;
  assign flush_ftq_id_o   = flush_ftq_q;
  assign csr_excp_o       = excp_q;
  assign csr_ertn_o       = ertn_q;
  assign csr_era_o        = era_q;
  assign excp_num_o       = excp_num_q;
  assign excp_tlbrefill_o = tlbr_q;
  assign inv_valid_o      = (state_q == ST_INV_WAIT);

`ifdef COMMIT_IDLE_FSM_EN
  assign in_idle_o = (state_q == ST_IDLE);
`else
  // Interrupts reach the pipeline only as slot exceptions in this build.
  logic unused_int_pending;
  assign unused_int_pending = int_pending_i;
  assign in_idle_o = 1'b0;
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// Self-checking bench for commit_ctrl (W=4): directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the commit rules.
module tb_commit_ctrl;
  localparam int W = 4;
  localparam int M_RUN = 0, M_INV = 1, M_IDLE = 2;

  logic clk, rst_n;
  logic [W-1:0]    slot_valid, slot_excp, slot_last;
  logic [W*32-1:0] slot_pc;
  logic [W*16-1:0] slot_num;
  logic [W*3-1:0]  slot_kind, slot_ftq;
  logic [31:0]     eentry, tlbrentry, csr_era;
  logic            int_pending, inv_ready;

  logic            commit_ready_o, redirect_valid_o, csr_excp_o, csr_ertn_o;
  logic            excp_tlbrefill_o, inv_valid_o, in_idle_o;
  logic [W-1:0]    commit_mask_o, block_commit_mask_o;
  logic [31:0]     redirect_pc_o, csr_era_o;
  logic [2:0]      flush_ftq_id_o;
  logic [15:0]     excp_num_o;

  int pass_cnt = 0, total_cnt = 0;

  commit_ctrl #(.COMMIT_WIDTH(W), .ADDR_WIDTH(32), .FTQ_ID_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .slot_valid_i(slot_valid), .slot_pc_i(slot_pc), .slot_excp_i(slot_excp),
    .slot_excp_num_i(slot_num), .slot_kind_i(slot_kind),
    .slot_last_in_block_i(slot_last), .slot_ftq_id_i(slot_ftq),
    .csr_eentry_i(eentry), .csr_tlbrentry_i(tlbrentry), .csr_era_i(csr_era),
    .int_pending_i(int_pending), .inv_ready_i(inv_ready),
    .commit_ready_o(commit_ready_o), .commit_mask_o(commit_mask_o),
    .block_commit_mask_o(block_commit_mask_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .flush_ftq_id_o(flush_ftq_id_o),
    .csr_excp_o(csr_excp_o), .csr_ertn_o(csr_ertn_o), .csr_era_o(csr_era_o),
    .excp_num_o(excp_num_o), .excp_tlbrefill_o(excp_tlbrefill_o),
    .inv_valid_o(inv_valid_o), .in_idle_o(in_idle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic v; logic [31:0] pc; logic [2:0] ftq; logic ex; logic er;
    logic [31:0] era; logic [15:0] num; logic tl;
  } redir_t;

  redir_t      m_pend;
  int          m_mode;
  logic [31:0] m_saved_pc;
  logic [2:0]  m_saved_ftq;
  logic        e_ready;
  logic [W-1:0] e_mask;
  logic [97:0] exp_vec;

  function automatic logic [97:0] obs_vec();
    return {commit_ready_o, commit_mask_o, block_commit_mask_o, redirect_valid_o,
            redirect_pc_o, flush_ftq_id_o, csr_excp_o, csr_ertn_o, csr_era_o,
            excp_num_o, excp_tlbrefill_o, inv_valid_o, in_idle_o};
  endfunction

  function automatic int first_boundary();
    for (int i = 0; i < W; i++)
      if (slot_valid[i] && (slot_excp[i] || slot_kind[i*3 +: 3] != 3'd0)) return i;
    return W;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mode = M_RUN; m_saved_pc = '0; m_saved_ftq = '0;
  endtask

  task automatic model_eval();
    int k;
    k = first_boundary();
    e_ready = (m_mode == M_RUN) && !m_pend.v;
    e_mask = '0;
    for (int i = 0; i < W; i++)
      if (e_ready && slot_valid[i] && (i < k || (i == k && !slot_excp[i]))) e_mask[i] = 1'b1;
    exp_vec = {e_ready, e_mask, e_mask & slot_last, m_pend.v, m_pend.pc, m_pend.ftq,
               m_pend.ex, m_pend.er, m_pend.era, m_pend.num, m_pend.tl,
               m_mode == M_INV, m_mode == M_IDLE};
  endtask

  task automatic model_tick();
    redir_t n;
    int k;
    logic [2:0] kd, fk;
    logic [15:0] num;
    logic [31:0] pck;
    n = '0;
    k = first_boundary();
    if (m_mode == M_RUN) begin
      if (e_ready && k < W) begin
        kd = slot_kind[k*3 +: 3]; num = slot_num[k*16 +: 16];
        pck = slot_pc[k*32 +: 32]; fk = slot_ftq[k*3 +: 3];
        if (slot_excp[k]) begin
          n.v = 1; n.ex = 1; n.era = pck; n.num = num; n.ftq = fk;
          n.tl = (num & 16'h0804) != 16'h0;
          n.pc = n.tl ? tlbrentry : eentry;
        end else if (kd == 3'd1) begin
          n.v = 1; n.er = 1; n.pc = csr_era; n.ftq = fk;
        end else if (kd == 3'd4) begin
          m_mode = M_INV; m_saved_pc = pck; m_saved_ftq = fk;
        end else if (kd == 3'd2) begin
`ifdef COMMIT_IDLE_FSM_EN
          m_mode = M_IDLE; m_saved_pc = pck; m_saved_ftq = fk;
`else
          n.v = 1; n.pc = pck; n.ftq = fk;
`endif
        end else begin
          n.v = 1; n.pc = pck + 32'd4; n.ftq = fk;
        end
      end
    end else if (m_mode == M_INV) begin
      if (inv_ready) begin
        n.v = 1; n.pc = m_saved_pc + 32'd4; n.ftq = m_saved_ftq; m_mode = M_RUN;
      end
    end else begin
      if (int_pending) begin
        n.v = 1; n.pc = eentry; n.ftq = m_saved_ftq; n.ex = 1;
        n.era = m_saved_pc + 32'd4; n.num = 16'h0001; m_mode = M_RUN;
      end
    end
    m_pend = n;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_slots();
    slot_valid = '0; slot_excp = '0; slot_last = '0; slot_pc = '0;
    slot_num = '0; slot_kind = '0; slot_ftq = '0;
  endtask

  task automatic set_slot(input int i, input logic [31:0] pc, input logic excp,
                          input logic [15:0] num, input logic [2:0] kind,
                          input logic last, input logic [2:0] ftq);
    slot_valid[i] = 1'b1; slot_pc[i*32 +: 32] = pc; slot_excp[i] = excp;
    slot_num[i*16 +: 16] = num; slot_kind[i*3 +: 3] = kind;
    slot_last[i] = last; slot_ftq[i*3 +: 3] = ftq;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    clear_slots(); int_pending = 0; inv_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_slots(); int_pending = 0; inv_ready = 0;
    eentry = 32'h1C00_1000; tlbrentry = 32'h1C00_8000; csr_era = 32'h0;
    rst_n = 1'b0;
    sample();
    total_cnt++; if (commit_ready_o !== 1'b1) $display("FAIL reset_ready: got %b expected 1", commit_ready_o); else pass_cnt++;
    total_cnt++; if (obs_vec() !== {1'b1, 97'h0}) $display("FAIL reset_outputs: got %h expected %h", obs_vec(), {1'b1, 97'h0}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    next_cycle(); sample();
    total_cnt++; if (obs_vec() !== {1'b1, 97'h0}) $display("FAIL reset_release: got %h expected %h", obs_vec(), {1'b1, 97'h0}); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_normal();
    clear_slots();
    set_slot(0, 32'h1C00_0000, 0, 16'h0, 3'd0, 0, 3'd1);
    set_slot(1, 32'h1C00_0004, 0, 16'h0, 3'd0, 1, 3'd1);
    sample();
    total_cnt++; if (commit_mask_o !== 4'b0011) $display("FAIL normal_mask: got %b expected 0011", commit_mask_o); else pass_cnt++;
    total_cnt++; if (block_commit_mask_o !== 4'b0010) $display("FAIL normal_block_mask: got %b expected 0010", block_commit_mask_o); else pass_cnt++;
    next_cycle(); clear_slots(); sample();
    total_cnt++; if (redirect_valid_o !== 1'b0) $display("FAIL normal_no_redirect: got %b expected 0", redirect_valid_o); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_tlbr_excp();
    clear_slots();
    set_slot(0, 32'h1C00_000C, 0, 16'h0,    3'd0, 0, 3'd4);
    set_slot(1, 32'h1C00_0010, 1, 16'h0800, 3'd0, 0, 3'd5);
    sample();
    total_cnt++; if (commit_mask_o !== 4'b0001) $display("FAIL tlbr_mask: got %b expected 0001", commit_mask_o); else pass_cnt++;
    next_cycle(); clear_slots(); sample();
    total_cnt++; if ({redirect_valid_o, csr_excp_o, excp_tlbrefill_o} !== 3'b111) $display("FAIL tlbr_pulses: got %b expected 111", {redirect_valid_o, csr_excp_o, excp_tlbrefill_o}); else pass_cnt++;
    total_cnt++; if (redirect_pc_o !== 32'h1C00_8000) $display("FAIL tlbr_pc: got %h expected 1c008000", redirect_pc_o); else pass_cnt++;
    total_cnt++; if (csr_era_o !== 32'h1C00_0010) $display("FAIL tlbr_era: got %h expected 1c000010", csr_era_o); else pass_cnt++;
    total_cnt++; if ({excp_num_o, flush_ftq_id_o} !== {16'h0800, 3'd5}) $display("FAIL tlbr_num_ftq: got %h/%0d expected 0800/5", excp_num_o, flush_ftq_id_o); else pass_cnt++;
    next_cycle(); sample();
    total_cnt++; if (redirect_valid_o !== 1'b0 || csr_excp_o !== 1'b0) $display("FAIL tlbr_one_cycle: got %b%b expected 00", redirect_valid_o, csr_excp_o); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_ertn();
    clear_slots(); csr_era = 32'h1C00_0200;
    set_slot(0, 32'h1C00_0100, 0, 16'h0, 3'd1, 0, 3'd2);
    set_slot(1, 32'h1C00_0104, 0, 16'h0, 3'd0, 0, 3'd2);
    sample();
    total_cnt++; if (commit_mask_o !== 4'b0001) $display("FAIL ertn_mask: got %b expected 0001", commit_mask_o); else pass_cnt++;
    next_cycle();
    clear_slots();
    set_slot(0, 32'h1C00_0300, 0, 16'h0, 3'd0, 0, 3'd3);
    set_slot(1, 32'h1C00_0304, 0, 16'h0, 3'd0, 1, 3'd3);
    sample();
    total_cnt++; if ({csr_ertn_o, redirect_valid_o, csr_excp_o} !== 3'b110) $display("FAIL ertn_pulses: got %b expected 110", {csr_ertn_o, redirect_valid_o, csr_excp_o}); else pass_cnt++;
    total_cnt++; if (redirect_pc_o !== 32'h1C00_0200) $display("FAIL ertn_pc: got %h expected 1c000200", redirect_pc_o); else pass_cnt++;
    total_cnt++; if (commit_mask_o !== 4'b0000) $display("FAIL ertn_wrong_path_mask: got %b expected 0000", commit_mask_o); else pass_cnt++;
    next_cycle(); clear_slots();
  endtask

  task automatic test_invtlb();
    clear_slots(); inv_ready = 0;
    set_slot(0, 32'h0000_0100, 0, 16'h0, 3'd4, 0, 3'd6);
    sample();
    total_cnt++; if (commit_mask_o !== 4'b0001) $display("FAIL inv_commit_mask: got %b expected 0001", commit_mask_o); else pass_cnt++;
    next_cycle();
    clear_slots();
    set_slot(0, 32'h0000_0104, 0, 16'h0, 3'd0, 0, 3'd7);
    for (int c = 0; c < 3; c++) begin
      inv_ready = (c == 2);
      sample();
      total_cnt++; if ({inv_valid_o, commit_ready_o, commit_mask_o, redirect_valid_o} !== 7'b1000000) $display("FAIL inv_wait_c%0d: got %b expected 1000000", c, {inv_valid_o, commit_ready_o, commit_mask_o, redirect_valid_o}); else pass_cnt++;
      next_cycle();
    end
    inv_ready = 0;
    sample();
    total_cnt++; if ({redirect_valid_o, inv_valid_o, commit_mask_o} !== 6'b100000) $display("FAIL inv_redirect_flags: got %b expected 100000", {redirect_valid_o, inv_valid_o, commit_mask_o}); else pass_cnt++;
    total_cnt++; if ({redirect_pc_o, flush_ftq_id_o} !== {32'h0000_0104, 3'd6}) $display("FAIL inv_redirect_pc: got %h/%0d expected 00000104/6", redirect_pc_o, flush_ftq_id_o); else pass_cnt++;
    next_cycle(); clear_slots();
  endtask

  task automatic test_idle();
    clear_slots(); int_pending = 0; eentry = 32'h1C00_1000;
    set_slot(0, 32'h0000_0200, 0, 16'h0, 3'd2, 0, 3'd1);
    sample();
    total_cnt++; if (commit_mask_o !== 4'b0001) $display("FAIL idle_commit_mask: got %b expected 0001", commit_mask_o); else pass_cnt++;
    next_cycle(); clear_slots();
`ifdef COMMIT_IDLE_FSM_EN
    for (int c = 0; c < 5; c++) begin
      int_pending = (c == 4);
      sample();
      total_cnt++; if ({in_idle_o, commit_ready_o, redirect_valid_o} !== 3'b100) $display("FAIL idle_wait_c%0d: got %b expected 100", c, {in_idle_o, commit_ready_o, redirect_valid_o}); else pass_cnt++;
      next_cycle();
    end
    int_pending = 0;
    sample();
    total_cnt++; if ({redirect_valid_o, csr_excp_o, excp_num_o, in_idle_o} !== {2'b11, 16'h0001, 1'b0}) $display("FAIL idle_wake_flags: got %b%b %h %b expected 11 0001 0", redirect_valid_o, csr_excp_o, excp_num_o, in_idle_o); else pass_cnt++;
    total_cnt++; if ({redirect_pc_o, csr_era_o} !== {32'h1C00_1000, 32'h0000_0204}) $display("FAIL idle_wake_pc_era: got %h/%h expected 1c001000/00000204", redirect_pc_o, csr_era_o); else pass_cnt++;
    next_cycle();
    // Interrupt already pending at the IDLE commit: still enters IDLE, wakes a cycle later.
    set_slot(0, 32'h0000_0300, 0, 16'h0, 3'd2, 0, 3'd2); int_pending = 1;
    next_cycle(); clear_slots(); sample();
    total_cnt++; if ({in_idle_o, redirect_valid_o} !== 2'b10) $display("FAIL idle_same_cycle_enter: got %b expected 10", {in_idle_o, redirect_valid_o}); else pass_cnt++;
    next_cycle(); int_pending = 0; sample();
    total_cnt++; if ({redirect_valid_o, csr_era_o} !== {1'b1, 32'h0000_0304}) $display("FAIL idle_same_cycle_wake: got %b/%h expected 1/00000304", redirect_valid_o, csr_era_o); else pass_cnt++;
    next_cycle();
`else
    sample();
    total_cnt++; if ({redirect_valid_o, redirect_pc_o, in_idle_o, csr_excp_o} !== {1'b1, 32'h0000_0200, 2'b00}) $display("FAIL idle_refetch_self: got %b/%h/%b%b expected 1/00000200/00", redirect_valid_o, redirect_pc_o, in_idle_o, csr_excp_o); else pass_cnt++;
    next_cycle(); sample();
    total_cnt++; if ({commit_ready_o, in_idle_o} !== 2'b10) $display("FAIL idle_off_state: got %b expected 10", {commit_ready_o, in_idle_o}); else pass_cnt++;
    next_cycle();
`endif
  endtask

  task automatic test_w4_excp_and_reset();
    clear_slots(); tlbrentry = 32'h1C00_8000;
    set_slot(0, 32'h0000_1000, 0, 16'h0,    3'd0, 0, 3'd0);
    set_slot(1, 32'h0000_1004, 0, 16'h0,    3'd0, 1, 3'd0);
    set_slot(2, 32'h0000_1008, 1, 16'h0004, 3'd0, 0, 3'd3);
    set_slot(3, 32'h0000_100C, 0, 16'h0,    3'd0, 1, 3'd3);
    sample();
    total_cnt++; if ({commit_mask_o, block_commit_mask_o} !== 8'b0011_0010) $display("FAIL w4_masks: got %b/%b expected 0011/0010", commit_mask_o, block_commit_mask_o); else pass_cnt++;
    next_cycle(); clear_slots(); sample();
    total_cnt++; if ({excp_tlbrefill_o, redirect_pc_o, csr_era_o} !== {1'b1, 32'h1C00_8000, 32'h0000_1008}) $display("FAIL w4_redirect: got %b/%h/%h expected 1/1c008000/00001008", excp_tlbrefill_o, redirect_pc_o, csr_era_o); else pass_cnt++;
    next_cycle();
    // Async reset in INV_WAIT aborts straight to RUN.
    set_slot(0, 32'h0000_0300, 0, 16'h0, 3'd4, 0, 3'd1); inv_ready = 0;
    next_cycle(); clear_slots(); sample();
    total_cnt++; if (inv_valid_o !== 1'b1) $display("FAIL rst_pre_inv_valid: got %b expected 1", inv_valid_o); else pass_cnt++;
    #1 rst_n = 1'b0; #1;
    total_cnt++; if (obs_vec() !== {1'b1, 97'h0}) $display("FAIL rst_mid_inv: got %h expected %h", obs_vec(), {1'b1, 97'h0}); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    next_cycle(); sample();
    total_cnt++; if (obs_vec() !== {1'b1, 97'h0}) $display("FAIL rst_after_inv: got %h expected %h", obs_vec(), {1'b1, 97'h0}); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_random();
    apply_reset();
    model_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < W; i++) begin
        slot_valid[i]        = $urandom_range(0, 3) != 0;
        slot_pc[i*32 +: 32]  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
        slot_excp[i]         = $urandom_range(0, 9) == 0;
        slot_num[i*16 +: 16] = 16'(32'd1 << $urandom_range(0, 15));
        slot_kind[i*3 +: 3]  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 4)) : 3'd0;
        slot_last[i]         = 1'($urandom_range(0, 1));
        slot_ftq[i*3 +: 3]   = 3'($urandom_range(0, 7));
      end
      eentry = 32'($urandom); tlbrentry = 32'($urandom); csr_era = 32'($urandom);
      inv_ready = $urandom_range(0, 3) == 0;
      int_pending = $urandom_range(0, 3) == 0;
      sample();
      model_eval();
      total_cnt++;
      if (obs_vec() !== exp_vec)
        $display("FAIL random_cyc%0d: got %h expected %h", cyc, obs_vec(), exp_vec);
      else pass_cnt++;
      model_tick();
      next_cycle();
    end
    clear_slots(); inv_ready = 0; int_pending = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_normal();
    test_tlbr_excp();
    test_ertn();
    test_invtlb();
    test_idle();
    test_w4_excp_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

Parametrised in-order commit controller for the backend writeback boundary. It accepts up to COMMIT_WIDTH writeback slots per cycle and resolves the commit mask. It selects the oldest exception or serialising instruction, and produces a registered redirect/flush with the matching CSR exception/ERTN pulses. It also sequences multi-cycle events through a small FSM: true IDLE waiting for an interrupt, and INVTLB completion handshake. It sits between the WB stage and the frontend/CSR/TLB units, generalising the fixed two-slot controller.

## Interface
- COMMIT_WIDTH, 2, number of commit slots (1..8); slot 0 is oldest
- ADDR_WIDTH, 32, PC width
- FTQ_ID_WIDTH, 3, FTQ index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- slot_valid_i  in  COMMIT_WIDTH  slot holds an instruction
- slot_pc_i  in  COMMIT_WIDTH*ADDR_WIDTH  per-slot PC
- slot_excp_i  in  COMMIT_WIDTH  slot raised an exception
- slot_excp_num_i  in  COMMIT_WIDTH*16  one-hot-priority exception vector (bit0 INT … bit15 PIL)
- slot_kind_i  in  COMMIT_WIDTH*3  0 normal, 1 ERTN, 2 IDLE, 3 refetch, 4 INVTLB
- slot_last_in_block_i  in  COMMIT_WIDTH  last instruction of a basic block
- slot_ftq_id_i  in  COMMIT_WIDTH*FTQ_ID_WIDTH  per-slot FTQ id
- csr_eentry_i, csr_tlbrentry_i, csr_era_i  in  ADDR_WIDTH each  redirect targets
- int_pending_i  in  1  enabled interrupt pending (from CSR)
- inv_ready_i  in  1  TLB finished invalidation
- commit_ready_o  out  1  block accepts slots this cycle
- commit_mask_o  out  COMMIT_WIDTH  slots architecturally committed (regfile/CSR write enable)
- block_commit_mask_o  out  COMMIT_WIDTH  committed slots that end a basic block
- redirect_valid_o  out  1  one-cycle flush + redirect pulse
- redirect_pc_o  out  ADDR_WIDTH  redirect target
- flush_ftq_id_o  out  FTQ_ID_WIDTH  FTQ id of the redirecting slot
- csr_excp_o, csr_ertn_o  out  1 each  pulses, aligned with redirect_valid_o
- csr_era_o  out  ADDR_WIDTH  ERA to latch on csr_excp_o
- excp_num_o  out  16  exception vector to CSR
- excp_tlbrefill_o  out  1  exception is TLB refill
- inv_valid_o  out  1  INVTLB request to TLB, held until accepted
- in_idle_o  out  1  FSM in IDLE

## Operation
- The boundary slot k is the lowest index with slot_valid_i & (slot_excp_i | slot_kind_i≠0). If there is none, k=COMMIT_WIDTH.
- commit_mask_o[i] = commit_ready_o & slot_valid_i[i] & (i<k | (i==k & ~slot_excp_i[k])). Slots above k are discarded.
- Redirect event at k:
  - Exception → target tlbrentry if excp_num bit2 or bit11, else eentry; csr_excp pulse; ERA=pc[k].
  - ERTN → csr_era_i; csr_ertn pulse.
  - refetch → pc[k]+4.
  - IDLE → enter IDLE, no redirect.
  - INVTLB → enter INV_WAIT.
- FSM states RUN, INV_WAIT, IDLE.
  - RUN→INV_WAIT on committed INVTLB. inv_valid_o=1 until the cycle inv_ready_i=1, then redirect to saved pc+4 and go to RUN.
  - RUN→IDLE on committed IDLE. In IDLE, when int_pending_i=1: redirect to eentry, csr_excp_o=1, excp_num_o=16'h0001, csr_era_o=idle pc+4, then go to RUN.
- commit_ready_o=1 only in RUN. In INV_WAIT and IDLE all slots are ignored (upstream flushed).
- The saved PC register holds pc[k] of the serialising slot.
- Arithmetic: pc+4 is modulo 2^ADDR_WIDTH.

## Timing
- commit_mask_o and block_commit_mask_o are combinational, same cycle as the slots.
- Redirect, CSR pulses, excp_num_o and csr_era_o are registered: they appear one cycle after the boundary slot and last exactly one cycle.
- In a cycle where redirect_valid_o=1, commit_mask_o must be 0; those slots are wrong-path.
- INVTLB redirect fires the cycle after inv_ready_i is sampled high. If inv_ready_i is already high in the entry cycle, the redirect comes 2 cycles after commit.
- Reset (async assert, sync release):
  - FSM=RUN, commit_ready_o=1.
  - All other outputs 0, saved PC 0.
- Reset mid-INV_WAIT or mid-IDLE aborts to RUN with no redirect.
- If int_pending_i rises in the same cycle as the IDLE commit, still enter IDLE; wake on the next cycle.

## Configuration
- COMMIT_IDLE_FSM_EN defined: IDLE state as above.
- COMMIT_IDLE_FSM_EN undefined:
  - IDLE is treated as refetch-to-self: redirect to pc[k] with no state change.
  - in_idle_o is tied 0.
  - Interrupts arrive only through slot_excp_num_i.

## Test plan
- W=2, both slots normal valid, slot1 last_in_block → commit_mask=11, block_commit_mask=10, no redirect.
- Slot0 normal, slot1 excp_num=16'h0800, pc=0x1C000010, tlbrentry=0x1C008000 → commit_mask=01; next cycle redirect_pc=0x1C008000, excp_tlbrefill=1, csr_era=0x1C000010.
- Slot0 ERTN, csr_era_i=0x1C000200 → commit_mask=01; next cycle csr_ertn=1, redirect_pc=0x1C000200; slots presented in that cycle get mask=00.
- INVTLB at pc 0x100, inv_ready_i high after 3 cycles → inv_valid held 3 cycles, commit_ready=0, then redirect_pc=0x104.
- IDLE at pc 0x200 (macro on), int_pending after 5 cycles → in_idle=1 for the wait; then csr_excp=1, excp_num=0x0001, csr_era=0x204, redirect_pc=eentry. With the macro off → redirect_pc=0x200, in_idle=0.
- W=4, slot2 excp, slot3 valid → commit_mask=0011; rst_n asserted during INV_WAIT → outputs at reset values immediately.
